// File: rtl/fct_credit_ctrl_pkg.sv
// Shared SpaceWire flow-control definitions: FCT FSM encodings and
// default credit / buffer sizing.
package fct_credit_ctrl_pkg;

    localparam int MAX_CREDIT_DEF   = 56;
    localparam int FCT_CHUNK_DEF    = 8;
    localparam int RX_BUF_DEPTH_DEF = 56;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } fct_state_e;

endpackage

// File: rtl/fct_credit_ctrl_fsm.sv
// FCT request FSM: raises fct_req when the receive side has room for one
// more FCT worth of N-chars, holds it until acknowledged, then settles.
module fct_fsm
    import fct_credit_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic room,
    input  logic fct_ack,
    output logic fct_req,
    output logic grant
);

    fct_state_e state;

    // An ack only counts while a request is actually outstanding.
    assign grant = (state == REQ) && fct_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            fct_req <= 1'b0;
        end else if (!enable) begin
            state   <= IDLE;
            fct_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (room) begin
                        state   <= REQ;
                        fct_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (fct_ack) begin
                        state   <= SETTLE;
                        fct_req <= 1'b0;
                    end
                end
                SETTLE: begin
                    state   <= IDLE;
                    fct_req <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    fct_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fct_credit_ctrl.sv
// SpaceWire flow-control credit controller: transmit credit, receive
// occupancy and outstanding-grant tracking, with a sticky error flag.
module fct_credit_ctrl
    import fct_credit_ctrl_pkg::*;
#(
    parameter int MAX_CREDIT   = MAX_CREDIT_DEF,
    parameter int FCT_CHUNK    = FCT_CHUNK_DEF,
    parameter int RX_BUF_DEPTH = RX_BUF_DEPTH_DEF
) (
    input  logic       posedge_clk,
    input  logic       rx_reset,
    input  logic       enable,
    input  logic       got_fct,
    input  logic       tx_nchar_sent,
    input  logic       rx_nchar_wr,
    input  logic       rx_nchar_rd,
    input  logic       fct_ack,
    output logic       fct_req,
    output logic [5:0] tx_credit,
    output logic       tx_credit_ok,
    output logic [5:0] rx_outstanding,
    output logic       credit_error
);

    logic [5:0] occupancy;
    logic       sent_ok, fct_ok, fct_err;
    logic [5:0] tx_after;
    logic       wr_only, rd_only, occ_full, occ_err;
    logic       out_dec, out_err;
    logic       room, grant;

    // Spending happens first so a same-cycle FCT sees the reduced credit.
    assign sent_ok  = tx_nchar_sent && (tx_credit != 6'd0);
    assign tx_after = tx_credit - {5'd0, sent_ok};
    assign fct_ok   = got_fct &&
                      ({1'b0, tx_after} + 7'(FCT_CHUNK) <= 7'(MAX_CREDIT));
    assign fct_err  = got_fct && !fct_ok;

    assign wr_only  = rx_nchar_wr && !rx_nchar_rd;
    assign rd_only  = rx_nchar_rd && !rx_nchar_wr;
    assign occ_full = occupancy == 6'(RX_BUF_DEPTH);
    assign occ_err  = wr_only && occ_full;

    assign out_dec  = rx_nchar_wr && (rx_outstanding != 6'd0);
    assign out_err  = rx_nchar_wr && (rx_outstanding == 6'd0);

    // Free space is compared in wider arithmetic so it can never wrap.
    assign room = ({2'b0, occupancy} + {2'b0, rx_outstanding}
                   + 8'(FCT_CHUNK) <= 8'(RX_BUF_DEPTH)) &&
                  (rx_outstanding <= 6'(MAX_CREDIT - FCT_CHUNK));

    assign tx_credit_ok = tx_credit != 6'd0;

    fct_fsm u_fsm (
        .clk     (posedge_clk),
        .rst     (rx_reset),
        .enable  (enable),
        .room    (room),
        .fct_ack (fct_ack),
        .fct_req (fct_req),
        .grant   (grant)
    );

    always_ff @(posedge posedge_clk or posedge rx_reset) begin
        if (rx_reset) begin
            tx_credit      <= 6'd0;
            rx_outstanding <= 6'd0;
            occupancy      <= 6'd0;
            credit_error   <= 1'b0;
        end else if (!enable) begin
            tx_credit      <= 6'd0;
            rx_outstanding <= 6'd0;
            occupancy      <= 6'd0;
            credit_error   <= 1'b0;
        end else begin
            tx_credit <= tx_after + (fct_ok ? 6'(FCT_CHUNK) : 6'd0);

            rx_outstanding <= rx_outstanding
                              + (grant ? 6'(FCT_CHUNK) : 6'd0)
                              - {5'd0, out_dec};

            if (wr_only && !occ_full)
                occupancy <= occupancy + 6'd1;
            else if (rd_only && occupancy != 6'd0)
                occupancy <= occupancy - 6'd1;

            if (fct_err || occ_err || out_err)
                credit_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fct_credit_ctrl.sv
// Directed bench for fct_credit_ctrl: grant sequence, credit limits,
// occupancy boundaries, enable-low and asynchronous reset clearing.
module tb_fct_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       got_fct, tx_nchar_sent, rx_nchar_wr, rx_nchar_rd, fct_ack;
    logic       fct_req;
    logic [5:0] tx_credit;
    logic       tx_credit_ok;
    logic [5:0] rx_outstanding;
    logic       credit_error;

    int checks = 0;
    int errors = 0;

    fct_credit_ctrl dut (
        .posedge_clk    (clk),
        .rx_reset       (rst),
        .enable         (enable),
        .got_fct        (got_fct),
        .tx_nchar_sent  (tx_nchar_sent),
        .rx_nchar_wr    (rx_nchar_wr),
        .rx_nchar_rd    (rx_nchar_rd),
        .fct_ack        (fct_ack),
        .fct_req        (fct_req),
        .tx_credit      (tx_credit),
        .tx_credit_ok   (tx_credit_ok),
        .rx_outstanding (rx_outstanding),
        .credit_error   (credit_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fct(input int n);
        for (int i = 0; i < n; i++) begin
            got_fct = 1'b1;
            tick();
            got_fct = 1'b0;
        end
    endtask

    task automatic pulse_wr(input int n);
        for (int i = 0; i < n; i++) begin
            rx_nchar_wr = 1'b1;
            tick();
            rx_nchar_wr = 1'b0;
        end
    endtask

    task automatic pulse_rd(input int n);
        for (int i = 0; i < n; i++) begin
            rx_nchar_rd = 1'b1;
            tick();
            rx_nchar_rd = 1'b0;
        end
    endtask

    task automatic both_tx();
        got_fct       = 1'b1;
        tx_nchar_sent = 1'b1;
        tick();
        got_fct       = 1'b0;
        tx_nchar_sent = 1'b0;
    endtask

    task automatic toggle_enable();
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b0;
        got_fct = 1'b0;
        tx_nchar_sent = 1'b0;
        rx_nchar_wr = 1'b0;
        rx_nchar_rd = 1'b0;
        fct_ack = 1'b0;
        #22;
        chk("rst_req", fct_req, 0);
        chk("rst_tx", tx_credit, 0);
        chk("rst_ok", tx_credit_ok, 0);
        chk("rst_out", rx_outstanding, 0);
        chk("rst_err", credit_error, 0);

        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        tick();
        chk("req_first", fct_req, 1);

        for (int k = 1; k <= 7; k++) begin
            n = 0;
            while (!fct_req && n < 5) begin
                tick();
                n++;
            end
            chk("req_wait", fct_req, 1);
            fct_ack = 1'b1;
            tick();
            fct_ack = 1'b0;
            chk("out_grant", rx_outstanding, 8 * k);
            chk("settle_low", fct_req, 0);
        end
        repeat (4) tick();
        chk("req_full", fct_req, 0);
        chk("out_full", rx_outstanding, 56);

        fct_ack = 1'b1;
        tick();
        fct_ack = 1'b0;
        chk("ack_ignored", rx_outstanding, 56);

        pulse_wr(56);
        chk("wr_out", rx_outstanding, 0);
        chk("wr_occ", dut.occupancy, 56);
        chk("wr_err", credit_error, 0);
        chk("wr_req", fct_req, 0);

        pulse_wr(1);
        chk("ovr_err", credit_error, 1);
        chk("ovr_out", rx_outstanding, 0);
        chk("ovr_occ", dut.occupancy, 56);

        pulse_rd(6);
        repeat (2) tick();
        chk("rd_occ50", dut.occupancy, 50);
        chk("rd_noreq", fct_req, 0);
        pulse_rd(1);
        repeat (2) tick();
        chk("rd_free7", fct_req, 0);
        pulse_rd(1);
        tick();
        chk("rd_req", fct_req, 1);
        chk("err_sticky", credit_error, 1);

        enable = 1'b0;
        tick();
        chk("en_req", fct_req, 0);
        chk("en_out", rx_outstanding, 0);
        chk("en_occ", dut.occupancy, 0);
        chk("en_err", credit_error, 0);

        enable = 1'b1;
        pulse_fct(7);
        chk("tx56", tx_credit, 56);
        chk("tx56_ok", tx_credit_ok, 1);
        chk("tx56_err", credit_error, 0);
        pulse_fct(1);
        chk("tx_ovf", tx_credit, 56);
        chk("tx_ovf_err", credit_error, 1);

        toggle_enable();
        tx_nchar_sent = 1'b1;
        tick();
        tx_nchar_sent = 1'b0;
        chk("sent0_tx", tx_credit, 0);
        chk("sent0_err", credit_error, 0);

        pulse_fct(7);
        both_tx();
        chk("both56_tx", tx_credit, 55);
        chk("both56_err", credit_error, 1);

        toggle_enable();
        pulse_fct(6);
        chk("tx48", tx_credit, 48);
        both_tx();
        chk("both48_tx", tx_credit, 55);
        chk("both48_err", credit_error, 0);
        tx_nchar_sent = 1'b1;
        tick();
        tx_nchar_sent = 1'b0;
        chk("sent_tx", tx_credit, 54);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_req", fct_req, 0);
        chk("arst_tx", tx_credit, 0);
        chk("arst_ok", tx_credit_ok, 0);
        chk("arst_out", rx_outstanding, 0);
        chk("arst_occ", dut.occupancy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_req", fct_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
